// File: rtl/audio_fifo_i2s.sv
// audio_fifo_i2s: stereo frame FIFO feeding a free-running I2S serializer, 64 BCLK slots per frame.
// Optional macro UNDERRUN_HOLD_EN: an underrun frame repeats the last popped frame instead of silence.
module audio_fifo_i2s #(
   parameter int DEPTH    = 16,
   parameter int BCLK_DIV = 4
) (
   input  logic                     CLK,
   input  logic                     RESET_N,
   input  logic                     ENABLE,
   input  logic                     LD_FIFO,
   input  logic [31:0]              TONE,
   output logic                     FIFO_FULL,
   output logic [$clog2(DEPTH):0]   LEVEL,
   output logic                     BCLK,
   output logic                     LRCLK,
   output logic                     DACDAT,
   output logic                     UNDERRUN
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int DW = $clog2(BCLK_DIV);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   logic [31:0]   mem_q [DEPTH];

   logic [DW-1:0] div_q, div_d;
   logic          bclk_q, bclk_d;
   logic [5:0]    slot_q, slot_d;
   state_t        state_q, state_d;
   logic          lrclk_q, lrclk_d;
   logic          dacdat_q, dacdat_d;
   logic          underrun_q, underrun_d;
   logic [31:0]   shreg_q, shreg_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          full_q, full_d;
`ifdef UNDERRUN_HOLD_EN
   logic [31:0]   last_q, last_d;
`endif

   logic          tc_s, fall_s, wrap_s, pop_s, wr_s, rd_s;
   logic [31:0]   frame_s;

   // Next-state logic for divider, slot counter, FSM, FIFO bookkeeping and serializer.
   always_comb begin
      tc_s   = (div_q == DW'(BCLK_DIV - 1));
      fall_s = tc_s && bclk_q;
      wrap_s = fall_s && (slot_q == 6'd63);

      if (tc_s) begin
         div_d  = '0;
         bclk_d = ~bclk_q;
      end else begin
         div_d  = div_q + DW'(1);
         bclk_d = bclk_q;
      end

      if (fall_s) begin
         slot_d = slot_q + 6'd1;
      end else begin
         slot_d = slot_q;
      end

      // Mode changes only at the frame wrap so a started frame always finishes.
      state_d = state_q;
      if (wrap_s) begin
         case (state_q)
            IDLE: begin
               if (ENABLE && (level_q >= LW'(DEPTH / 2))) begin
                  state_d = RUN;
               end else begin
                  state_d = IDLE;
               end
            end
            RUN: begin
               if (!ENABLE) begin
                  state_d = IDLE;
               end else begin
                  state_d = RUN;
               end
            end
            default: state_d = IDLE;
         endcase
      end else begin
         state_d = state_q;
      end

      pop_s      = wrap_s && (state_d == RUN);
      rd_s       = pop_s && (level_q != '0);
      wr_s       = LD_FIFO && !full_q;
      underrun_d = pop_s && (level_q == '0);

`ifdef UNDERRUN_HOLD_EN
      if (rd_s) begin
         frame_s = mem_q[rd_ptr_q];
         last_d  = mem_q[rd_ptr_q];
      end else begin
         frame_s = last_q;
         last_d  = last_q;
      end
`else
      if (rd_s) begin
         frame_s = mem_q[rd_ptr_q];
      end else begin
         frame_s = 32'h0000_0000;
      end
`endif

      if (wr_s) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (rd_s) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end

      case ({wr_s, rd_s})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
      full_d = (level_d == LW'(DEPTH));

      // Slot 0 of each channel is the one-bit I2S delay; 16 sample bits follow MSB first.
      lrclk_d  = lrclk_q;
      dacdat_d = dacdat_q;
      shreg_d  = shreg_q;
      if (fall_s) begin
         if (state_d == RUN) begin
            lrclk_d = slot_d[5];
            if (pop_s) begin
               shreg_d  = frame_s;
               dacdat_d = 1'b0;
            end else if ((slot_d[4:0] >= 5'd1) && (slot_d[4:0] <= 5'd16)) begin
               dacdat_d = shreg_q[31];
               shreg_d  = {shreg_q[30:0], 1'b0};
            end else begin
               dacdat_d = 1'b0;
            end
         end else begin
            lrclk_d  = 1'b0;
            dacdat_d = 1'b0;
         end
      end else begin
         lrclk_d  = lrclk_q;
         dacdat_d = dacdat_q;
      end
   end

   // Frame storage; contents are don't-care after reset so it carries no reset.
   always_ff @(posedge CLK) begin
      if (wr_s) begin
         mem_q[wr_ptr_q] <= TONE;
      end
   end

   // All control state and registered outputs.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         div_q      <= '0;
         bclk_q     <= 1'b0;
         slot_q     <= 6'd0;
         state_q    <= IDLE;
         lrclk_q    <= 1'b0;
         dacdat_q   <= 1'b0;
         underrun_q <= 1'b0;
         shreg_q    <= 32'h0000_0000;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         full_q     <= 1'b0;
`ifdef UNDERRUN_HOLD_EN
         last_q     <= 32'h0000_0000;
`endif
      end else begin
         div_q      <= div_d;
         bclk_q     <= bclk_d;
         slot_q     <= slot_d;
         state_q    <= state_d;
         lrclk_q    <= lrclk_d;
         dacdat_q   <= dacdat_d;
         underrun_q <= underrun_d;
         shreg_q    <= shreg_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         full_q     <= full_d;
`ifdef UNDERRUN_HOLD_EN
         last_q     <= last_d;
`endif
      end
   end

   assign FIFO_FULL = full_q;
   assign LEVEL     = level_q;
   assign BCLK      = bclk_q;
   assign LRCLK     = lrclk_q;
   assign DACDAT    = dacdat_q;
   assign UNDERRUN  = underrun_q;

endmodule

// File: tb/tb_audio_fifo_i2s.sv
// Directed bench for audio_fifo_i2s (DEPTH=16, BCLK_DIV=4): frames are 512 CLK, slots 8 CLK.
module tb_audio_fifo_i2s;
   logic        CLK = 1'b0;
   logic        RESET_N;
   logic        ENABLE;
   logic        LD_FIFO;
   logic [31:0] TONE;
   logic        FIFO_FULL;
   logic [4:0]  LEVEL;
   logic        BCLK;
   logic        LRCLK;
   logic        DACDAT;
   logic        UNDERRUN;

   int checks = 0;
   int fails  = 0;

   logic [31:0] fr [9] = '{32'h8000_7FFF, 32'h1234_ABCD, 32'hFFFF_0001, 32'h0F0F_F0F0,
                          32'hA5A5_5A5A, 32'h0001_8000, 32'h7FFF_8000, 32'hC3C3_3C3C,
                          32'hDEAD_BEEF};
   logic [31:0] ur_frame;

   audio_fifo_i2s #(.DEPTH(16), .BCLK_DIV(4)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .ENABLE(ENABLE), .LD_FIFO(LD_FIFO), .TONE(TONE),
      .FIFO_FULL(FIFO_FULL), .LEVEL(LEVEL), .BCLK(BCLK), .LRCLK(LRCLK),
      .DACDAT(DACDAT), .UNDERRUN(UNDERRUN)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic write(input logic [31:0] d);
      LD_FIFO = 1'b1;
      TONE    = d;
      tick(1);
      LD_FIFO = 1'b0;
   endtask

   // Starts just after the edge entering slot 0, ends just after the next slot-0 edge.
   task automatic chk_frame(input string tag, input bit exp_run, input logic [31:0] exp_frame,
                            input int exp_ur, input bit wr_end, input logic [31:0] wr_data);
      logic [15:0] l, r;
      int pad, lr_err, bclk_err, ur;
      l = 16'h0; r = 16'h0; pad = 0; lr_err = 0; bclk_err = 0; ur = 0;
      for (int c = 0; c < 512; c++) begin
         int n;
         n = c / 8;
         if ((c % 8) == 0) begin
            if (n >= 1 && n <= 16) l = {l[14:0], DACDAT};
            else if (n >= 33 && n <= 48) r = {r[14:0], DACDAT};
            else if (DACDAT !== 1'b0) pad++;
            if (LRCLK !== (exp_run && (n >= 32))) lr_err++;
         end
         if (BCLK !== ((c % 8) >= 4)) bclk_err++;
         if (UNDERRUN !== 1'b0) ur++;
         if (c == 511 && wr_end) begin
            LD_FIFO = 1'b1;
            TONE    = wr_data;
         end
         tick(1);
         LD_FIFO = 1'b0;
      end
      chk({tag, "_left"},  32'(l), 32'(exp_frame[31:16]));
      chk({tag, "_right"}, 32'(r), 32'(exp_frame[15:0]));
      chk({tag, "_pad"},   32'(pad), 32'd0);
      chk({tag, "_lrclk"}, 32'(lr_err), 32'd0);
      chk({tag, "_bclk"},  32'(bclk_err), 32'd0);
      chk({tag, "_underrun"}, 32'(ur), 32'(exp_ur));
   endtask

   initial begin
`ifdef UNDERRUN_HOLD_EN
      ur_frame = 32'hDEAD_BEEF;
`else
      ur_frame = 32'h0000_0000;
`endif
      RESET_N = 1'b0; ENABLE = 1'b0; LD_FIFO = 1'b0; TONE = 32'h0;
      tick(3);
      chk("rst_full", 32'(FIFO_FULL), 32'd0);
      chk("rst_level", 32'(LEVEL), 32'd0);
      chk("rst_bclk", 32'(BCLK), 32'd0);
      chk("rst_lrclk", 32'(LRCLK), 32'd0);
      chk("rst_dacdat", 32'(DACDAT), 32'd0);
      chk("rst_underrun", 32'(UNDERRUN), 32'd0);

      // Fill to full, then one dropped write.
      RESET_N = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         write(32'h0001_0002);
         if (i == 3)  chk("bclk_c3", 32'(BCLK), 32'd0);
         if (i == 4)  chk("bclk_c4", 32'(BCLK), 32'd1);
         if (i == 8)  chk("bclk_c8", 32'(BCLK), 32'd0);
         if (i == 15) chk("full_at15", 32'(FIFO_FULL), 32'd0);
         if (i == 16) chk("full_at16", 32'(FIFO_FULL), 32'd1);
         if (i == 16) chk("level_at16", 32'(LEVEL), 32'd16);
      end
      write(32'h0BAD_0BAD);
      chk("level_drop", 32'(LEVEL), 32'd16);
      chk("full_drop", 32'(FIFO_FULL), 32'd1);

      RESET_N = 1'b0;
      #1;
      chk("rst2_level", 32'(LEVEL), 32'd0);
      chk("rst2_full", 32'(FIFO_FULL), 32'd0);
      tick(2);

      // Streaming: 8 frames, RUN at first wrap (CLK 512 after release).
      RESET_N = 1'b1;
      ENABLE  = 1'b1;
      for (int i = 0; i < 8; i++) write(fr[i]);
      chk("level_loaded", 32'(LEVEL), 32'd8);
      tick(292);
      chk("idle_lrclk", 32'(LRCLK), 32'd0);
      chk("idle_dacdat", 32'(DACDAT), 32'd0);
      tick(212);
      chk("level_first_pop", 32'(LEVEL), 32'd7);
      chk_frame("f0", 1'b1, fr[0], 0, 1'b0, 32'h0);
      chk_frame("f1", 1'b1, fr[1], 0, 1'b0, 32'h0);
      chk("level_before_simul", 32'(LEVEL), 32'd5);
      chk_frame("f2", 1'b1, fr[2], 0, 1'b1, fr[8]);
      chk("level_simul", 32'(LEVEL), 32'd5);
      for (int i = 3; i <= 8; i++) chk_frame($sformatf("f%0d", i), 1'b1, fr[i], 0, 1'b0, 32'h0);
      chk("level_drained", 32'(LEVEL), 32'd0);
      chk_frame("u1", 1'b1, ur_frame, 1, 1'b0, 32'h0);
      ENABLE = 1'b0;
      chk_frame("u2", 1'b1, ur_frame, 1, 1'b0, 32'h0);
      chk_frame("idle", 1'b0, 32'h0, 0, 1'b0, 32'h0);

      // Reset asserted at slot 20 of a running frame.
      ENABLE = 1'b1;
      for (int i = 0; i < 8; i++) write(fr[i]);
      tick(504);
      chk("level_run2", 32'(LEVEL), 32'd7);
      tick(164);
      chk("bclk_pre_rst", 32'(BCLK), 32'd1);
      RESET_N = 1'b0;
      #1;
      chk("mid_rst_bclk", 32'(BCLK), 32'd0);
      chk("mid_rst_lrclk", 32'(LRCLK), 32'd0);
      chk("mid_rst_dacdat", 32'(DACDAT), 32'd0);
      chk("mid_rst_underrun", 32'(UNDERRUN), 32'd0);
      chk("mid_rst_full", 32'(FIFO_FULL), 32'd0);
      chk("mid_rst_level", 32'(LEVEL), 32'd0);
      tick(2);
      RESET_N = 1'b1;
      tick(4);
      chk("restart_bclk", 32'(BCLK), 32'd1);
      tick(296);
      chk("restart_idle_lrclk", 32'(LRCLK), 32'd0);
      chk("restart_level", 32'(LEVEL), 32'd0);
      for (int i = 1; i <= 8; i++) write(fr[i]);
      tick(204);
      chk("restart_pop_level", 32'(LEVEL), 32'd7);
      chk_frame("post_rst", 1'b1, fr[1], 0, 1'b0, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
